seq_mult_ctrl: RTL and testbench
================================

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; product width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1: request to multiply a by b; sampled each rising edge.
REQ-005 SHALL have port a, input, WIDTH: multiplicand, unsigned.
REQ-006 SHALL have port b, input, WIDTH: multiplier, unsigned.
REQ-007 SHALL have port busy, output, 1: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1: single-cycle pulse marking a valid new product.
REQ-009 SHALL have port product, output, 2*WIDTH: registered result a*b, unsigned.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE; only these states are reachable.
REQ-011 SHALL, in IDLE or DONE with start=1 at edge N, capture a and b into internal registers, clear the accumulator and the iteration counter, and enter RUN.
REQ-012 SHALL ignore start in RUN: no operand recapture, no restart, no state change.
REQ-013 SHALL, per RUN cycle, add the shifted multiplicand to the accumulator when the current multiplier LSB is 1, then shift: multiplicand left 1, multiplier right 1.
REQ-014 SHALL perform exactly WIDTH RUN iterations, on edges N+1 through N+WIDTH, regardless of operand values (fixed latency, no early exit on zero).
REQ-015 SHALL size the accumulator at 2*WIDTH bits; no carry is lost for any operand pair (max 15*15=225 at WIDTH=4).
REQ-016 SHALL load product from the final accumulator value at edge N+WIDTH and enter DONE.
REQ-017 SHALL drive done=1 only in DONE, for exactly one cycle per completed operation.
REQ-018 SHALL drive busy=1 exactly in RUN; busy and done are never both 1.
REQ-019 SHALL, in DONE with start=0, return to IDLE on the next edge.
REQ-020 SHALL, in DONE with start=1, accept the new request per REQ-011 (back-to-back; done still pulses that cycle).
REQ-021 SHALL hold product unchanged from one completion until the next completion; a new start does not clear it.
REQ-022 SHALL be idle-to-done latency WIDTH+1 edges: start sampled at edge N, done high after edge N+WIDTH.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, enter IDLE and drive busy=0, done=0 and product=0.
REQ-024 SHALL clear the operand registers, accumulator and counter on reset.
REQ-025 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse and no product update.
REQ-026 SHALL give reset priority over start at the same edge.
REQ-027 SHALL accept start on the first edge after rst_n returns to 1.

Structure
REQ-028 SHALL take the state enum type (IDLE/RUN/DONE) and the default width constant from shared package mult_pkg.
REQ-029 SHALL be split into a controller FSM (this module) and one datapath sub-module, shift_add_dp, which holds the operand registers, the accumulator and the shift/add logic under load/step enables.
REQ-030 SHALL register all outputs; no combinational path from start, a or b to any output.

Verification
REQ-031 SHALL cover: reset, then a=15, b=15, start one cycle -> busy high 4 cycles, done pulse after edge N+4, product=225.
REQ-032 SHALL cover: a=0, b=9 -> product=0, done still exactly after edge N+4.
REQ-033 SHALL cover: a=3, b=5 started, then start=1 with a=7, b=7 during RUN -> product=15, one done pulse, second request ignored.
REQ-034 SHALL cover: start held high continuously with a=6, b=7 -> done pulse every 5 cycles, product=42 each time, busy low only in DONE cycles.
REQ-035 SHALL cover: rst_n=0 two cycles into RUN (a=9, b=9) -> IDLE, product=0, no done; a new start of 2*3 then gives product=6.
REQ-036 SHALL cover: exhaustive 256 operand pairs at WIDTH=4 -> every product equals a*b, done count equals start count.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the sequential shift-add multiplier.
//                Provides the controller state encoding and the default
//                operand width used by both the controller and the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Default operand width in bits; products are twice this width.
  localparam int DEFAULT_WIDTH = 4;

  // Width of the encoded controller state.
  localparam int STATE_W = 2;

  // Controller states. The fourth encoding (2'b11) is unused and recovers
  // to IDLE in the next-state logic.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of an iteration counter able to hold the values 0 .. width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_dp.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_dp
//  Description : Shift-and-add datapath for the sequential multiplier.
//                Holds the multiplicand, multiplier and accumulator
//                registers. A load pulse captures new operands and clears
//                the accumulator; each step pulse performs one iteration:
//                conditionally add the multiplicand, then shift the
//                multiplicand left and the multiplier right.
//
//  Ports
//    clk      in   rising-edge clock
//    rst_n    in   synchronous active-low reset, clears all registers
//    load     in   capture a/b and clear the accumulator
//    step     in   perform one shift-add iteration
//    a        in   [WIDTH-1:0]   multiplicand, unsigned
//    b        in   [WIDTH-1:0]   multiplier, unsigned
//    acc_nxt  out  [2*WIDTH-1:0] accumulator value after the current step
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_nxt
);

  localparam int PW = 2 * WIDTH;

  // Multiplicand is kept at full product width so left shifts never lose
  // bits across the WIDTH iterations.
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;

  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_sum;

  // Partial product for this iteration: multiplicand or zero, chosen by
  // the current multiplier LSB.
  assign w_addend  = r_mplier[0] ? r_mcand : {PW{1'b0}};
  // Sum cannot overflow PW bits: the largest accumulated value is
  // (2^WIDTH-1)^2 < 2^PW.
  assign w_acc_sum = r_acc + w_addend;
  assign acc_nxt   = w_acc_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= {PW{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {PW{1'b0}};
    end else if (load) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= {PW{1'b0}};
    end else if (step) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule : shift_add_dp
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_ctrl
//  Description : Sequential unsigned multiplier, controller and top level.
//                A three-state FSM (IDLE/RUN/DONE) sequences the
//                shift_add_dp datapath through exactly WIDTH iterations,
//                then latches the result into the product register and
//                pulses done for one cycle. start is ignored while RUN;
//                a start seen in DONE begins the next operation
//                back-to-back.
//
//  Ports
//    clk      in   rising-edge clock
//    rst_n    in   synchronous active-low reset
//    start    in   request to multiply a by b
//    a        in   [WIDTH-1:0]   multiplicand, unsigned
//    b        in   [WIDTH-1:0]   multiplier, unsigned
//    busy     out  high while an operation is in progress (registered)
//    done     out  one-cycle pulse on a new product (registered)
//    product  out  [2*WIDTH-1:0] last completed a*b (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int              CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_acc_nxt;

  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  // --------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------
  shift_add_dp #(
    .WIDTH   (WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .step    (w_step),
    .a       (a),
    .b       (b),
    .acc_nxt (w_acc_nxt)
  );

  // Final iteration: the counter holds the index of the step being taken.
  assign w_last = (r_cnt == C_LAST);

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------
  // Next-state and datapath enables
  // --------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here.
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Iteration counter
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_load) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_step && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------
  // Output registers
  // busy/done are decoded from the next state and registered, so they
  // line up exactly with RUN/DONE without any combinational path from
  // the inputs. product only changes on the final iteration edge, so a
  // reset mid-operation or a new start leaves it alone (reset clears it).
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= {(2*WIDTH){1'b0}};
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
      if (w_step && w_last) begin
        r_product <= w_acc_nxt;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule : seq_mult_ctrl
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_ctrl
//  Description : Directed self-checking bench for seq_mult_ctrl (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_ctrl;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int total    = 0;
  int passed   = 0;
  int done_cnt = 0;
  int d0;
  int last_prod;

  seq_mult_ctrl #(
    .WIDTH   (WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation from IDLE: start for one edge, then follow RUN until done.
  task automatic run_op(input int ta, input int tbv, input int exp, input string tag);
    int cyc;
    a     = ta[WIDTH-1:0];
    b     = tbv[WIDTH-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 8) begin
      check({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
      check({tag, "_hold"}, {24'd0, product}, last_prod);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 4);
    check({tag, "_product"}, {24'd0, product}, exp);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 0);
    tick();
    check({tag, "_single_pulse"}, {31'd0, done}, 0);
    last_prod = exp;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    last_prod = 0;

    // Reset state
    tick();
    tick();
    check("rst_busy_done", {30'd0, busy, done}, 0);
    check("rst_product", {24'd0, product}, 0);
    rst_n = 1'b1;

    // Max operands and zero multiplicand
    run_op(15, 15, 225, "mul_15x15");
    run_op(0, 9, 0, "mul_0x9");

    // start held during RUN with new operands is ignored
    d0    = done_cnt;
    a     = 4'd3;
    b     = 4'd5;
    start = 1'b1;
    tick();
    a = 4'd7;
    b = 4'd7;
    repeat (3) begin
      check("ign_busy", {30'd0, busy, done}, 2);
      tick();
    end
    start = 1'b0;
    check("ign_busy_last", {30'd0, busy, done}, 2);
    tick();
    check("ign_done", {30'd0, busy, done}, 1);
    check("ign_product", {24'd0, product}, 15);
    tick();
    check("ign_after", {30'd0, busy, done}, 0);
    repeat (5) tick();
    check("ign_hold", {24'd0, product}, 15);
    check("ign_one_done", done_cnt - d0, 1);
    last_prod = 15;

    // start held continuously: back-to-back operations every 5 cycles
    a     = 4'd6;
    b     = 4'd7;
    start = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      repeat (4) begin
        check("b2b_busy", {30'd0, busy, done}, 2);
        tick();
      end
      check("b2b_done", {30'd0, busy, done}, 1);
      check("b2b_product", {24'd0, product}, 42);
      if (p == 2) start = 1'b0;
      tick();
    end
    check("b2b_idle", {30'd0, busy, done}, 0);
    last_prod = 42;

    // Reset two cycles into RUN, reset priority over start
    a     = 4'd9;
    b     = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy", {30'd0, busy, done}, 2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_state", {30'd0, busy, done}, 0);
    check("mid_rst_product", {24'd0, product}, 0);
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd5;
    tick();
    check("rst_prio", {30'd0, busy, done}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    d0    = done_cnt;
    repeat (5) tick();
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_idle", {30'd0, busy, done}, 0);
    last_prod = 0;

    // start on the first edge after reset release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_op(2, 3, 6, "mul_2x3");

    // Exhaustive operand sweep
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(i, j, i * j, "sweep");
      end
    end
    check("sweep_done_count", done_cnt - d0, 256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_seq_mult_ctrl
`default_nettype wire
